// File: rtl/control_sequencer.sv
// Microcode sequencer for the 8-bit bus CPU: a T-state counter plus opcode/flag decode
// producing one active-high control word per clock, with sticky HLT.
module control_sequencer #(
  parameter int unsigned MAX_STEPS = 5,
  parameter bit          EARLY_END = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] opcode_i,
  input  logic       carry_flag_i,
  input  logic       zero_flag_i,
  output logic [2:0] step_o,
  output logic       halted_o,
  output logic       mar_in_o,
  output logic       ram_in_o,
  output logic       ram_out_o,
  output logic       ir_out_o,
  output logic       ir_in_o,
  output logic       a_in_o,
  output logic       a_out_o,
  output logic       alu_out_o,
  output logic       alu_sub_o,
  output logic       b_in_o,
  output logic       out_in_o,
  output logic       flags_in_o,
  output logic       pc_inc_o,
  output logic       pc_out_o,
  output logic       pc_jump_o
);

  localparam logic [2:0] StT0 = 3'd0;
  localparam logic [2:0] StT1 = 3'd1;
  localparam logic [2:0] StT2 = 3'd2;
  localparam logic [2:0] StT3 = 3'd3;
  localparam logic [2:0] StT4 = 3'd4;
  localparam logic [2:0] LastStep = 3'(MAX_STEPS - 1);

  localparam int BitMarIn   = 14;
  localparam int BitRamIn   = 13;
  localparam int BitRamOut  = 12;
  localparam int BitIrOut   = 11;
  localparam int BitIrIn    = 10;
  localparam int BitAIn     = 9;
  localparam int BitAOut    = 8;
  localparam int BitAluOut  = 7;
  localparam int BitAluSub  = 6;
  localparam int BitBIn     = 5;
  localparam int BitOutIn   = 4;
  localparam int BitFlagsIn = 3;
  localparam int BitPcInc   = 2;
  localparam int BitPcOut   = 1;
  localparam int BitPcJump  = 0;

  logic [2:0]  step_q, step_d;
  logic        halted_q, halted_d;
  logic [14:0] word_raw, word;
  logic        halt_set;

  always_comb begin
    word_raw = '0;
    case (step_q)
      StT0: begin
        word_raw[BitPcOut] = 1'b1;
        word_raw[BitMarIn] = 1'b1;
      end
      StT1: begin
        word_raw[BitRamOut] = 1'b1;
        word_raw[BitIrIn]   = 1'b1;
        word_raw[BitPcInc]  = 1'b1;
      end
      default: begin
        case (opcode_i)
          4'h1, 4'h2, 4'h3, 4'h4: begin
            if (step_q == StT2) begin
              word_raw[BitIrOut] = 1'b1;
              word_raw[BitMarIn] = 1'b1;
            end else if (step_q == StT3) begin
              word_raw[BitRamOut] = (opcode_i != 4'h4);
              word_raw[BitAIn]    = (opcode_i == 4'h1);
              word_raw[BitBIn]    = (opcode_i == 4'h2) || (opcode_i == 4'h3);
              word_raw[BitAOut]   = (opcode_i == 4'h4);
              word_raw[BitRamIn]  = (opcode_i == 4'h4);
            end else if (step_q == StT4 && (opcode_i == 4'h2 || opcode_i == 4'h3)) begin
              word_raw[BitAluOut]  = 1'b1;
              word_raw[BitAIn]     = 1'b1;
              word_raw[BitFlagsIn] = 1'b1;
              word_raw[BitAluSub]  = (opcode_i == 4'h3);
            end
          end
          4'h5: if (step_q == StT2) begin
            word_raw[BitIrOut] = 1'b1;
            word_raw[BitAIn]   = 1'b1;
          end
          // Conditional jumps only look at the flags in T2.
          4'h6, 4'h7, 4'h8: begin
            if (step_q == StT2 && (opcode_i == 4'h6 || (opcode_i == 4'h7 && carry_flag_i) ||
                                   (opcode_i == 4'h8 && zero_flag_i))) begin
              word_raw[BitIrOut]  = 1'b1;
              word_raw[BitPcJump] = 1'b1;
            end
          end
          4'hE: if (step_q == StT2) begin
            word_raw[BitAOut]  = 1'b1;
            word_raw[BitOutIn] = 1'b1;
          end
          default: ;
        endcase
      end
    endcase
  end

  assign word     = (rst_i || halted_q) ? '0 : word_raw;
  assign halt_set = !halted_q && (step_q == StT2) && (opcode_i == 4'hF);

  always_comb begin
    halted_d = halted_q || halt_set;
    if (halted_q || halt_set) begin
      step_d = step_q;
    end else if (step_q == LastStep) begin
      step_d = StT0;
    end else if (EARLY_END && step_q >= StT2 && word_raw == '0) begin
      step_d = StT0;
    end else begin
      step_d = step_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      step_q   <= StT0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  assign step_o     = step_q;
  assign halted_o   = halted_q;
  assign mar_in_o   = word[BitMarIn];
  assign ram_in_o   = word[BitRamIn];
  assign ram_out_o  = word[BitRamOut];
  assign ir_out_o   = word[BitIrOut];
  assign ir_in_o    = word[BitIrIn];
  assign a_in_o     = word[BitAIn];
  assign a_out_o    = word[BitAOut];
  assign alu_out_o  = word[BitAluOut];
  assign alu_sub_o  = word[BitAluSub];
  assign b_in_o     = word[BitBIn];
  assign out_in_o   = word[BitOutIn];
  assign flags_in_o = word[BitFlagsIn];
  assign pc_inc_o   = word[BitPcInc];
  assign pc_out_o   = word[BitPcOut];
  assign pc_jump_o  = word[BitPcJump];

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: directed instruction traces with hand-computed
// control words, plus a per-cycle bus/PC invariant check over an opcode/flag sweep.
module tb_control_sequencer;

  localparam logic [14:0] MAR  = 15'h4000;
  localparam logic [14:0] RAMI = 15'h2000;
  localparam logic [14:0] RAMO = 15'h1000;
  localparam logic [14:0] IRO  = 15'h0800;
  localparam logic [14:0] IRI  = 15'h0400;
  localparam logic [14:0] AI   = 15'h0200;
  localparam logic [14:0] AO   = 15'h0100;
  localparam logic [14:0] ALUO = 15'h0080;
  localparam logic [14:0] SUBT = 15'h0040;
  localparam logic [14:0] BI   = 15'h0020;
  localparam logic [14:0] OUTI = 15'h0010;
  localparam logic [14:0] FI   = 15'h0008;
  localparam logic [14:0] PCI  = 15'h0004;
  localparam logic [14:0] PCO  = 15'h0002;
  localparam logic [14:0] PCJ  = 15'h0001;
  localparam logic [14:0] F0   = PCO | MAR;
  localparam logic [14:0] F1   = RAMO | IRI | PCI;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic       carry, zero;
  logic [2:0] step;
  logic       halted;
  logic mar_in, ram_in, ram_out, ir_out, ir_in, a_in, a_out, alu_out, alu_sub, b_in;
  logic out_in, flags_in, pc_inc, pc_out, pc_jump;
  logic [14:0] act_word;

  control_sequencer dut (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .carry_flag_i(carry), .zero_flag_i(zero),
    .step_o(step), .halted_o(halted), .mar_in_o(mar_in), .ram_in_o(ram_in),
    .ram_out_o(ram_out), .ir_out_o(ir_out), .ir_in_o(ir_in), .a_in_o(a_in), .a_out_o(a_out),
    .alu_out_o(alu_out), .alu_sub_o(alu_sub), .b_in_o(b_in), .out_in_o(out_in),
    .flags_in_o(flags_in), .pc_inc_o(pc_inc), .pc_out_o(pc_out), .pc_jump_o(pc_jump)
  );

  always #5 clk = ~clk;

  assign act_word = {mar_in, ram_in, ram_out, ir_out, ir_in, a_in, a_out, alu_out, alu_sub,
                     b_in, out_in, flags_in, pc_inc, pc_out, pc_jump};

  typedef struct {
    logic [2:0]  step;
    logic        halt;
    logic [14:0] word;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;

  // Monitor: the control word is presented every cycle; sample mid-cycle.
  always @(negedge clk) begin
    checks++;
    if ((pc_inc && pc_jump) || $countones({pc_out, ram_out, ir_out, a_out, alu_out}) > 1) begin
      failures++;
      $display("FAIL invariant: op=%h step=%0d word=%h has pc_inc&pc_jump or >1 bus driver",
               opcode, step, act_word);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({step, halted, act_word} !== {e.step, e.halt, e.word}) begin
        failures++;
        $display("FAIL %s: step/halted/word got %0d/%0b/%h want %0d/%0b/%h", e.tag,
                 step, halted, act_word, e.step, e.halt, e.word);
      end
    end
  end

  task automatic cyc(input logic [3:0] op, input logic c, input logic z, input logic [2:0] s,
                     input logic [14:0] w, input logic h, input string tag);
    opcode = op;
    carry  = c;
    zero   = z;
    sb.push_back('{step: s, halt: h, word: w, tag: tag});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; opcode = 4'h1; carry = 1'b0; zero = 1'b0;
    @(posedge clk);
    #1;
    cyc(4'h1, 1'b0, 1'b0, 3'd0, 15'h0, 1'b0, "reset");
    rst = 1'b0;

    // LDA: T4 is all zero and the step wraps.
    cyc(4'h1, 1'b0, 1'b0, 3'd0, F0, 1'b0, "lda_t0");
    cyc(4'h1, 1'b0, 1'b0, 3'd1, F1, 1'b0, "lda_t1");
    cyc(4'h1, 1'b0, 1'b0, 3'd2, IRO | MAR, 1'b0, "lda_t2");
    cyc(4'h1, 1'b0, 1'b0, 3'd3, RAMO | AI, 1'b0, "lda_t3");
    cyc(4'h1, 1'b0, 1'b0, 3'd4, 15'h0, 1'b0, "lda_t4");
    // NOP: early end after T2.
    cyc(4'h0, 1'b0, 1'b0, 3'd0, F0, 1'b0, "nop_t0");
    cyc(4'h0, 1'b0, 1'b0, 3'd1, F1, 1'b0, "nop_t1");
    cyc(4'h0, 1'b0, 1'b0, 3'd2, 15'h0, 1'b0, "nop_t2");
    // SUB: full five steps, wrap 4->0.
    cyc(4'h3, 1'b0, 1'b0, 3'd0, F0, 1'b0, "sub_t0");
    cyc(4'h3, 1'b0, 1'b0, 3'd1, F1, 1'b0, "sub_t1");
    cyc(4'h3, 1'b0, 1'b0, 3'd2, IRO | MAR, 1'b0, "sub_t2");
    cyc(4'h3, 1'b0, 1'b0, 3'd3, RAMO | BI, 1'b0, "sub_t3");
    cyc(4'h3, 1'b0, 1'b0, 3'd4, ALUO | AI | SUBT | FI, 1'b0, "sub_t4");
    // JC taken; carry only high at T2.
    cyc(4'h7, 1'b0, 1'b0, 3'd0, F0, 1'b0, "jc1_t0");
    cyc(4'h7, 1'b0, 1'b0, 3'd1, F1, 1'b0, "jc1_t1");
    cyc(4'h7, 1'b1, 1'b0, 3'd2, IRO | PCJ, 1'b0, "jc1_t2");
    cyc(4'h7, 1'b0, 1'b0, 3'd3, 15'h0, 1'b0, "jc1_t3");
    // JC not taken; carry high at T0/T1 has no effect.
    cyc(4'h7, 1'b1, 1'b0, 3'd0, F0, 1'b0, "jc0_t0");
    cyc(4'h7, 1'b1, 1'b0, 3'd1, F1, 1'b0, "jc0_t1");
    cyc(4'h7, 1'b0, 1'b0, 3'd2, 15'h0, 1'b0, "jc0_t2");
    // JZ taken then not taken.
    cyc(4'h8, 1'b0, 1'b0, 3'd0, F0, 1'b0, "jz1_t0");
    cyc(4'h8, 1'b0, 1'b0, 3'd1, F1, 1'b0, "jz1_t1");
    cyc(4'h8, 1'b0, 1'b1, 3'd2, IRO | PCJ, 1'b0, "jz1_t2");
    cyc(4'h8, 1'b0, 1'b1, 3'd3, 15'h0, 1'b0, "jz1_t3");
    cyc(4'h8, 1'b0, 1'b0, 3'd0, F0, 1'b0, "jz0_t0");
    cyc(4'h8, 1'b0, 1'b0, 3'd1, F1, 1'b0, "jz0_t1");
    cyc(4'h8, 1'b1, 1'b0, 3'd2, 15'h0, 1'b0, "jz0_t2");
    // STA, LDI, OUT execute words.
    cyc(4'h4, 1'b0, 1'b0, 3'd0, F0, 1'b0, "sta_t0");
    cyc(4'h4, 1'b0, 1'b0, 3'd1, F1, 1'b0, "sta_t1");
    cyc(4'h4, 1'b0, 1'b0, 3'd2, IRO | MAR, 1'b0, "sta_t2");
    cyc(4'h4, 1'b0, 1'b0, 3'd3, AO | RAMI, 1'b0, "sta_t3");
    cyc(4'h5, 1'b0, 1'b0, 3'd4, 15'h0, 1'b0, "sta_t4");
    cyc(4'h5, 1'b0, 1'b0, 3'd0, F0, 1'b0, "ldi_t0");
    cyc(4'h5, 1'b0, 1'b0, 3'd1, F1, 1'b0, "ldi_t1");
    cyc(4'h5, 1'b0, 1'b0, 3'd2, IRO | AI, 1'b0, "ldi_t2");
    cyc(4'h5, 1'b0, 1'b0, 3'd3, 15'h0, 1'b0, "ldi_t3");
    cyc(4'hE, 1'b0, 1'b0, 3'd0, F0, 1'b0, "out_t0");
    cyc(4'hE, 1'b0, 1'b0, 3'd1, F1, 1'b0, "out_t1");
    cyc(4'hE, 1'b0, 1'b0, 3'd2, AO | OUTI, 1'b0, "out_t2");
    cyc(4'hE, 1'b0, 1'b0, 3'd3, 15'h0, 1'b0, "out_t3");
    // HLT: halted from the cycle after T2, step frozen at 2.
    cyc(4'hF, 1'b0, 1'b0, 3'd0, F0, 1'b0, "hlt_t0");
    cyc(4'hF, 1'b0, 1'b0, 3'd1, F1, 1'b0, "hlt_t1");
    cyc(4'hF, 1'b0, 1'b0, 3'd2, 15'h0, 1'b0, "hlt_t2");
    for (int i = 0; i < 20; i++) begin
      cyc(4'(i), 1'b1, 1'b1, 3'd2, 15'h0, 1'b1, "hlt_hold");
    end
    rst = 1'b1;
    cyc(4'h1, 1'b0, 1'b0, 3'd0, 15'h0, 1'b0, "hlt_rst");
    rst = 1'b0;
    // ADD with an asynchronous reset between edges during T3.
    cyc(4'h2, 1'b0, 1'b0, 3'd0, F0, 1'b0, "add_t0");
    cyc(4'h2, 1'b0, 1'b0, 3'd1, F1, 1'b0, "add_t1");
    cyc(4'h2, 1'b0, 1'b0, 3'd2, IRO | MAR, 1'b0, "add_t2");
    opcode = 4'h2;
    #2;
    rst = 1'b1;
    sb.push_back('{step: 3'd0, halt: 1'b0, word: 15'h0, tag: "add_async_rst"});
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(4'h2, 1'b0, 1'b0, 3'd0, F0, 1'b0, "add_after_rst");

    // Sweep every opcode and flag pair through a full instruction.
    for (int op = 0; op < 16; op++) begin
      for (int f = 0; f < 4; f++) begin
        opcode = 4'(op);
        carry  = f[0];
        zero   = f[1];
        rst    = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
      end
    end

    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
